// File: rtl/ghost_fleet_move.sv
// ghost_fleet_move: time-multiplexed fixed-point motion engine servicing a fleet of maze ghosts once per frame
module ghost_fleet_move #(
  parameter int NUM_GHOSTS = 4,
  parameter int FP_SHIFT = 6,
  parameter int SPEED = 60,
  parameter int FRIGHT_SPEED = 30,
  parameter int OBJECT_W = 32,
  parameter int OBJECT_H = 32,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int INITIAL_X = 100,
  parameter int INITIAL_Y = 100,
  parameter int X_SPACING = 80,
  parameter int DIR_CHANGE_FRAMES = 150,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     restart,
  input  logic                     startOfFrame,
  input  logic                     stop,
  input  logic                     frightened,
  input  logic [NUM_GHOSTS-1:0]    collision,
  input  logic [4*NUM_GHOSTS-1:0]  HitEdgeCode,
  input  logic [NUM_GHOSTS-1:0]    collision_pac,
  output logic [11*NUM_GHOSTS-1:0] topLeftX,
  output logic [11*NUM_GHOSTS-1:0] topLeftY,
  output logic [2*NUM_GHOSTS-1:0]  direction,
  output logic                     busy,
  output logic                     overrun
);
  localparam int IW = NUM_GHOSTS > 1 ? $clog2(NUM_GHOSTS) : 1;
  localparam int ONE = 1 << FP_SHIFT;
  localparam int X_MAX = (SCREEN_W - 1 - OBJECT_W) << FP_SHIFT;
  localparam int Y_MAX = (SCREEN_H - 1 - OBJECT_H) << FP_SHIFT;
  localparam int HOME_Y = INITIAL_Y << FP_SHIFT;
  typedef enum logic [1:0] {IDLE, TURN, MOVE, LIMIT} state_t;
  state_t state, state_n;
  logic signed [31:0] px [NUM_GHOSTS];
  logic signed [31:0] py [NUM_GHOSTS];
  logic [1:0] pd [NUM_GHOSTS];
  logic [3:0] edge_pend [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] hit_pend, pac_pend, clr;
  logic [IW-1:0] idx;
  logic [7:0] lfsr;
  logic [31:0] frame_cnt;
  logic signed [31:0] speed, wx, wy, hx, tx, ty, mx, my, lx, ly;
  logic [1:0] wd, cd, td, ld;
  logic [3:0] ce;
  logic turn_now, last, facing;
  always_comb begin
    last = idx == IW'(NUM_GHOSTS - 1);
    state_n = state == IDLE ? (startOfFrame && !stop ? TURN : IDLE)
            : state == TURN ? MOVE : state == MOVE ? LIMIT : (last ? IDLE : TURN);
    clr = state == TURN ? NUM_GHOSTS'(1) << idx : '0;
    cd = pd[idx];
    ce = edge_pend[idx];
    hx = 32'((INITIAL_X + int'(idx) * X_SPACING) << FP_SHIFT);
    // edge bits are {left,top,right,bottom}; dir 0..2 map to bits 2..0, left is bit 3
    facing = cd == 2'd3 ? ce[3] : ce[2'd2 - cd];
    tx = pac_pend[idx] ? hx : hit_pend[idx] ? px[idx] + (ce[3] ? ONE : 0) - (ce[1] ? ONE : 0) : px[idx];
    ty = pac_pend[idx] ? HOME_Y : hit_pend[idx] ? py[idx] + (ce[2] ? ONE : 0) - (ce[0] ? ONE : 0) : py[idx];
    td = pac_pend[idx] ? 2'd1 : hit_pend[idx] && facing ? cd + 2'd2
       : turn_now ? (lfsr[3'(idx)] ? cd + 2'd1 : cd - 2'd1) : cd;
    mx = wd == 2'd1 ? wx + speed : wd == 2'd3 ? wx - speed : wx;
    my = wd == 2'd2 ? wy + speed : wd == 2'd0 ? wy - speed : wy;
    lx = wx < ONE ? ONE : wx > X_MAX ? X_MAX : wx;
    ly = wy < ONE ? ONE : wy > Y_MAX ? Y_MAX : wy;
    ld = wx < ONE && wd == 2'd3 ? 2'd1 : wx > X_MAX && wd == 2'd1 ? 2'd3
       : wy < ONE && wd == 2'd0 ? 2'd2 : wy > Y_MAX && wd == 2'd2 ? 2'd0 : wd;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      lfsr <= LFSR_SEED;
      frame_cnt <= '0;
      overrun <= 1'b0;
      speed <= '0;
      turn_now <= 1'b0;
      wx <= '0;
      wy <= '0;
      wd <= '0;
      hit_pend <= '0;
      pac_pend <= '0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        px[i] <= 32'((INITIAL_X + i * X_SPACING) << FP_SHIFT);
        py[i] <= HOME_Y;
        pd[i] <= 2'd1;
        edge_pend[i] <= '0;
      end
    end else if (restart) begin
      state <= IDLE;
      idx <= '0;
      lfsr <= LFSR_SEED;
      frame_cnt <= '0;
      overrun <= 1'b0;
      speed <= '0;
      turn_now <= 1'b0;
      wx <= '0;
      wy <= '0;
      wd <= '0;
      hit_pend <= '0;
      pac_pend <= '0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        px[i] <= 32'((INITIAL_X + i * X_SPACING) << FP_SHIFT);
        py[i] <= HOME_Y;
        pd[i] <= 2'd1;
        edge_pend[i] <= '0;
      end
    end else begin
      state <= state_n;
      // a strobe landing on its ghost's clearing cycle survives into the next frame
      hit_pend <= hit_pend & ~clr | collision;
      pac_pend <= pac_pend & ~clr | collision_pac;
      for (int i = 0; i < NUM_GHOSTS; i++)
        edge_pend[i] <= edge_pend[i] & {4{~clr[i]}} | (collision[i] ? HitEdgeCode[4*i +: 4] : 4'd0);
      if (state != IDLE && startOfFrame) overrun <= 1'b1;
      if (state == IDLE && startOfFrame && !stop) begin
        speed <= frightened ? 32'(FRIGHT_SPEED) : 32'(SPEED);
        turn_now <= frame_cnt == 32'(DIR_CHANGE_FRAMES - 1);
      end
      if (state == TURN) begin
        wx <= tx;
        wy <= ty;
        wd <= td;
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      if (state == MOVE) begin
        wx <= mx;
        wy <= my;
      end
      if (state == LIMIT) begin
        px[idx] <= lx;
        py[idx] <= ly;
        pd[idx] <= ld;
        idx <= last ? '0 : idx + 1'b1;
        if (last) frame_cnt <= frame_cnt == 32'(DIR_CHANGE_FRAMES - 1) ? '0 : frame_cnt + 32'd1;
      end
    end
  end
  assign busy = state != IDLE;
  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_out
    assign topLeftX[11*g +: 11] = 11'(px[g] >>> FP_SHIFT);
    assign topLeftY[11*g +: 11] = 11'(py[g] >>> FP_SHIFT);
    assign direction[2*g +: 2] = pd[g];
  end
endmodule

// File: tb/tb_ghost_fleet_move.sv
// tb_ghost_fleet_move: scoreboard bench; a behavioural ghost model predicts every ghost after each pass
module tb_ghost_fleet_move;
  localparam int NG = 4;
  localparam int D = 300;
  typedef struct packed { logic [10:0] x; logic [10:0] y; logic [1:0] d; } exp_t;
  logic clk = 1'b0, reset = 1'b1, restart = 1'b0, startOfFrame = 1'b0, stop = 1'b0, frightened = 1'b0;
  logic [NG-1:0] collision = '0, collision_pac = '0;
  logic [4*NG-1:0] HitEdgeCode = '0;
  logic [11*NG-1:0] topLeftX, topLeftY;
  logic [2*NG-1:0] direction;
  logic busy, overrun;
  int tests = 0, fails = 0;
  exp_t q[$];
  int mx[NG], my[NG], mfc;
  logic [1:0] md[NG];
  logic [3:0] medge[NG];
  bit mhit[NG], mpac[NG];
  logic [7:0] ml;

  ghost_fleet_move #(.NUM_GHOSTS(NG), .DIR_CHANGE_FRAMES(D)) dut (
    .clk(clk), .reset(reset), .restart(restart), .startOfFrame(startOfFrame), .stop(stop),
    .frightened(frightened), .collision(collision), .HitEdgeCode(HitEdgeCode),
    .collision_pac(collision_pac), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .direction(direction), .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  function automatic logic [10:0] gx(input int g); return topLeftX[11*g +: 11]; endfunction
  function automatic logic [10:0] gy(input int g); return topLeftY[11*g +: 11]; endfunction
  function automatic logic [1:0] gd(input int g); return direction[2*g +: 2]; endfunction

  task automatic model_reset();
    for (int g = 0; g < NG; g++) begin
      mx[g] = (100 + 80 * g) * 64;
      my[g] = 100 * 64;
      md[g] = 2'd1;
      medge[g] = '0;
      mhit[g] = 0;
      mpac[g] = 0;
    end
    ml = 8'hA5;
    mfc = 0;
    q.delete();
  endtask

  task automatic model_pass(input bit fr);
    int spd;
    bit tn, fc;
    exp_t e;
    spd = fr ? 30 : 60;
    tn = (mfc == D - 1);
    for (int g = 0; g < NG; g++) begin
      if (mpac[g]) begin
        mx[g] = (100 + 80 * g) * 64;
        my[g] = 6400;
        md[g] = 2'd1;
      end else begin
        if (mhit[g]) begin
          if (medge[g][3]) mx[g] = mx[g] + 64;
          if (medge[g][1]) mx[g] = mx[g] - 64;
          if (medge[g][2]) my[g] = my[g] + 64;
          if (medge[g][0]) my[g] = my[g] - 64;
        end
        fc = md[g] == 2'd0 ? medge[g][2] : md[g] == 2'd1 ? medge[g][1] : md[g] == 2'd2 ? medge[g][0] : medge[g][3];
        if (mhit[g] && fc) md[g] = md[g] + 2'd2;
        else if (tn) md[g] = ml[g % 8] ? md[g] + 2'd1 : md[g] - 2'd1;
      end
      mhit[g] = 0;
      mpac[g] = 0;
      medge[g] = '0;
      ml = {ml[6:0], ^(ml & 8'hB8)};
      case (md[g])
        2'd0: my[g] = my[g] - spd;
        2'd1: mx[g] = mx[g] + spd;
        2'd2: my[g] = my[g] + spd;
        default: mx[g] = mx[g] - spd;
      endcase
      if (mx[g] < 64) begin mx[g] = 64; if (md[g] == 2'd3) md[g] = 2'd1; end
      if (mx[g] > 607 * 64) begin mx[g] = 607 * 64; if (md[g] == 2'd1) md[g] = 2'd3; end
      if (my[g] < 64) begin my[g] = 64; if (md[g] == 2'd0) md[g] = 2'd2; end
      if (my[g] > 447 * 64) begin my[g] = 447 * 64; if (md[g] == 2'd2) md[g] = 2'd0; end
      e.x = 11'(mx[g] >>> 6);
      e.y = 11'(my[g] >>> 6);
      e.d = md[g];
      q.push_back(e);
    end
    mfc = (mfc == D - 1) ? 0 : mfc + 1;
  endtask

  // one pass; ev_kind 1=pac strobe on ev_g, 2=extra startOfFrame, 3=stop, driven at cycle ev_k
  task automatic run_frame(input bit fr, input int ev_k, input int ev_kind, input int ev_g);
    exp_t e;
    int g;
    frightened = fr;
    model_pass(fr);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_start got=%b exp=1", busy); end
    for (int k = 1; k <= 3 * NG; k++) begin
      @(negedge clk);
      if (k == ev_k + 1) begin collision_pac = '0; startOfFrame = 1'b0; stop = 1'b0; end
      if (k % 3 == 0) begin
        g = k / 3 - 1;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb_empty ghost%0d", g);
        end else begin
          e = q.pop_front();
          if ({gx(g), gy(g), gd(g)} !== e) begin
            fails++;
            $display("FAIL sb_ghost%0d got x=%0d y=%0d d=%0d exp x=%0d y=%0d d=%0d",
                     g, gx(g), gy(g), gd(g), e.x, e.y, e.d);
          end
        end
      end
      if (k == ev_k) begin
        if (ev_kind == 1) begin collision_pac[ev_g] = 1'b1; mpac[ev_g] = 1; end
        if (ev_kind == 2) startOfFrame = 1'b1;
        if (ev_kind == 3) stop = 1'b1;
      end
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_end got=%b exp=0", busy); end
    frightened = 1'b0;
  endtask

  task automatic soft_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NG; g++) begin
      tests++;
      if ({gx(g), gy(g), gd(g)} !== {11'(100 + 80 * g), 11'd100, 2'd1}) begin
        fails++;
        $display("FAIL reset_ghost%0d got x=%0d y=%0d d=%0d exp x=%0d y=100 d=1", g, gx(g), gy(g), gd(g), 100 + 80 * g);
      end
    end
    tests++;
    if ({busy, overrun} !== 2'b00) begin fails++; $display("FAIL reset_flags got busy=%b overrun=%b exp 0 0", busy, overrun); end
  endtask

  task automatic test_first_frame();
    run_frame(0, -1, 0, 0);
    tests++;
    if (gx(0) !== 11'd100 || gd(0) !== 2'd1) begin
      fails++;
      $display("FAIL first_frame got x=%0d d=%0d exp x=100 d=1", gx(0), gd(0));
    end
  endtask

  task automatic test_wall();
    collision[1] = 1'b1;
    HitEdgeCode[7:4] = 4'b0010;
    mhit[1] = 1;
    medge[1] = medge[1] | 4'b0010;
    @(negedge clk);
    collision = '0;
    HitEdgeCode = '0;
    run_frame(0, -1, 0, 0);
    tests++;
    if (gx(1) !== 11'd179 || gd(1) !== 2'd3) begin
      fails++;
      $display("FAIL wall_reverse got x=%0d d=%0d exp x=179 d=3", gx(1), gd(1));
    end
    run_frame(0, -1, 0, 0);
    tests++;
    if (gx(1) !== 11'd178) begin fails++; $display("FAIL wall_left got x=%0d exp 178", gx(1)); end
  endtask

  task automatic test_pac();
    run_frame(0, 10, 1, 2);
    run_frame(0, -1, 0, 0);
    tests++;
    if ({gx(2), gy(2), gd(2)} !== {11'd260, 11'd100, 2'd1}) begin
      fails++;
      $display("FAIL pac_home got x=%0d y=%0d d=%0d exp x=260 y=100 d=1", gx(2), gy(2), gd(2));
    end
    tests++;
    if (gx(3) !== 11'd344) begin fails++; $display("FAIL pac_other got x=%0d exp 344", gx(3)); end
  endtask

  task automatic test_pend_race();
    run_frame(0, 3, 1, 1);
    run_frame(0, -1, 0, 0);
    tests++;
    if (gx(1) !== 11'd180 || gd(1) !== 2'd1) begin
      fails++;
      $display("FAIL pend_race got x=%0d d=%0d exp x=180 d=1", gx(1), gd(1));
    end
  endtask

  task automatic test_fright();
    soft_restart();
    repeat (4) run_frame(1, -1, 0, 0);
    tests++;
    if (gx(0) !== 11'd101) begin fails++; $display("FAIL fright_step got x=%0d exp 101", gx(0)); end
  endtask

  task automatic test_overrun();
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
    run_frame(0, 5, 2, 0);
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL overrun_nostart got busy=%b exp=0", busy); end
    run_frame(0, -1, 0, 0);
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_stop();
    stop = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL stop_block got busy=%b exp=0", busy); end
    end
    tests++;
    if (gx(0) !== 11'(mx[0] >>> 6)) begin fails++; $display("FAIL stop_hold got x=%0d exp %0d", gx(0), mx[0] >>> 6); end
    stop = 1'b0;
    run_frame(0, 2, 3, 0);
  endtask

  task automatic test_boundary_turn();
    soft_restart();
    for (int f = 1; f <= D; f++) begin
      run_frame(0, -1, 0, 0);
      if (f == 284) begin
        tests++;
        if (gx(3) !== 11'd606 || gd(3) !== 2'd1) begin
          fails++;
          $display("FAIL edge_before got x=%0d d=%0d exp x=606 d=1", gx(3), gd(3));
        end
      end
      if (f == 285) begin
        tests++;
        if (gx(3) !== 11'd607 || gd(3) !== 2'd3) begin
          fails++;
          $display("FAIL edge_clamp got x=%0d d=%0d exp x=607 d=3", gx(3), gd(3));
        end
      end
    end
  endtask

  task automatic test_restart_mid_pass();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (2) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
    tests++;
    if ({busy, overrun} !== 2'b00) begin fails++; $display("FAIL restart_flags got busy=%b overrun=%b exp 0 0", busy, overrun); end
    for (int g = 0; g < NG; g++) begin
      tests++;
      if ({gx(g), gy(g), gd(g)} !== {11'(100 + 80 * g), 11'd100, 2'd1}) begin
        fails++;
        $display("FAIL restart_ghost%0d got x=%0d y=%0d d=%0d exp x=%0d y=100 d=1", g, gx(g), gy(g), gd(g), 100 + 80 * g);
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL restart_abort got busy=%b exp=0", busy); end
    run_frame(0, -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_wall();
    test_pac();
    test_pend_race();
    test_fright();
    test_overrun();
    test_stop();
    test_boundary_turn();
    test_restart_mid_pass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
